// File: rtl/dd_dip_decoder.sv
// DIP decoder: synchronises the frontend status word and OSD controls, then decodes them into the
// active-low DSW-A/B banks and the turbo flag. Define DIP_FILTER_EN to enable the stability filter.
module dd_dip_decoder #(
    parameter int unsigned STABLE_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] status,
    input  logic        dip_pause,
    input  logic        dip_test,
    input  logic        dip_flip,
    output logic [7:0]  dipsw_a,
    output logic [7:0]  dipsw_b,
    output logic        turbo
);

    // Vector layout: {flip, test, pause, status[31:16]}; neutral = not paused, not test, not flipped
    localparam logic [18:0] VecNeutral = {1'b0, 1'b1, 1'b1, 16'h0000};

    logic [18:0] w_in;
    logic [18:0] r_s1;
    logic [18:0] r_s2;
    logic [18:0] w_src;
    logic        w_load;
    logic [7:0]  w_dsw_a;
    logic [7:0]  w_dsw_b;
    logic        w_turbo;
    logic [7:0]  r_dsw_a;
    logic [7:0]  r_dsw_b;
    logic        r_turbo;
    logic        w_unused;

    assign w_in = {dip_flip, dip_test, dip_pause, status[31:16]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= VecNeutral;
            r_s2 <= VecNeutral;
        end else begin
            r_s1 <= w_in;
            r_s2 <= r_s1;
        end
    end

`ifdef DIP_FILTER_EN
    localparam logic [7:0] CntSat  = 8'(STABLE_CYC);
    localparam logic [7:0] CntLoad = 8'(STABLE_CYC - 1);

    logic [18:0] r_cand;
    logic [7:0]  r_cnt;

    // Any difference restarts the count, so multi-bit changes and mid-count bounces act as one event
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand <= VecNeutral;
            r_cnt  <= 8'd0;
        end else if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= 8'd0;
        end else if (r_cnt != CntSat) begin
            r_cnt  <= r_cnt + 8'd1;
        end
    end

    assign w_load   = (r_s2 == r_cand) && (r_cnt == CntLoad);
    assign w_src    = r_cand;
    assign w_unused = ^{status[15:0], w_src[15], w_src[13]};
`else
    assign w_load   = 1'b1;
    assign w_src    = r_s2;
    assign w_unused = ^{status[15:0], w_src[15], w_src[13], 8'(STABLE_CYC)};
`endif

    always_comb begin
        w_dsw_a = {w_src[17], ~w_src[18], ~w_src[5:3], ~w_src[2:0]};
        w_dsw_b = {~w_src[12:11], ~w_src[10:9], 1'b1, ~w_src[8], ~w_src[7:6]};
        w_turbo = w_src[14] & w_src[16];
    end

    // All three outputs share one load enable so they never show a mixed decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dsw_a <= 8'hFF;
            r_dsw_b <= 8'hFF;
            r_turbo <= 1'b0;
        end else if (w_load) begin
            r_dsw_a <= w_dsw_a;
            r_dsw_b <= w_dsw_b;
            r_turbo <= w_turbo;
        end
    end

    assign dipsw_a = r_dsw_a;
    assign dipsw_b = r_dsw_b;
    assign turbo   = r_turbo;

endmodule

// File: tb/tb_dd_dip_decoder.sv
// Scoreboard bench for dd_dip_decoder: stimulus pushes {value, cycle} expectations, a negedge
// monitor pops one entry on every output change and checks both value and arrival cycle.
module tb_dd_dip_decoder;

    localparam int S = 16;
`ifdef DIP_FILTER_EN
    localparam int  Lat  = S + 2;
    localparam bit  Filt = 1'b1;
`else
    localparam int  Lat  = 2;
    localparam bit  Filt = 1'b0;
`endif

    typedef struct {
        logic [16:0] val;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] status;
    logic        dip_pause;
    logic        dip_test;
    logic        dip_flip;
    logic [7:0]  dipsw_a;
    logic [7:0]  dipsw_b;
    logic        turbo;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;
    logic [16:0] prev;
    exp_t        q[$];

    dd_dip_decoder #(
        .STABLE_CYC(S)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .status   (status),
        .dip_pause(dip_pause),
        .dip_test (dip_test),
        .dip_flip (dip_flip),
        .dipsw_a  (dipsw_a),
        .dipsw_b  (dipsw_b),
        .turbo    (turbo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of {dipsw_a, dipsw_b, turbo} must match the next queued expectation
    always @(negedge clk) begin
        logic [16:0] cur;
        exp_t        e;
        cur = {dipsw_a, dipsw_b, turbo};
        if (mon_en && (cur !== prev)) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change cyc=%0d got=%h want=no change (was %h)",
                         cyc, cur, prev);
            end else begin
                e = q.pop_front();
                if (cur !== e.val || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL update got=%h@cyc%0d want=%h@cyc%0d", cur, cyc, e.val, e.cyc);
                end
            end
        end
        prev = cur;
    end

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] st, input logic p, input logic t, input logic f);
        status    = st;
        dip_pause = p;
        dip_test  = t;
        dip_flip  = f;
    endtask

    // Expected output change caused by inputs applied at the current negedge
    task automatic expect_upd(input logic [7:0] a, input logic [7:0] b, input logic tu);
        exp_t e;
        e.val = {a, b, tu};
        e.cyc = cyc + 1 + Lat;
        q.push_back(e);
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    localparam int H = S + 6;

    initial begin
        rst = 1'b1;
        apply(32'hFFFF_0000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_state", {dipsw_a, dipsw_b, turbo}, {8'hFF, 8'hFF, 1'b0});
        end
        rst = 1'b0;
        apply(32'h0000_0000, 1'b1, 1'b1, 1'b0);
        prev   = {dipsw_a, dipsw_b, turbo};
        mon_en = 1'b1;
        hold(S + 2);
        check("post_reset", {dipsw_a, dipsw_b, turbo}, {8'hFF, 8'hFF, 1'b0});

        // Coin A/B: status[21:16]=010_011 -> dipsw_a[5:0]=101_100
        apply(32'h0013_0000, 1'b1, 1'b1, 1'b0);
        expect_upd(8'hEC, 8'hFF, 1'b0);
        hold(H);

        // Turbo on, then forced off by pause, then back on
        apply(32'h4000_0000, 1'b1, 1'b1, 1'b0);
        expect_upd(8'hFF, 8'hFF, 1'b1);
        hold(H);
        apply(32'h4000_0000, 1'b0, 1'b1, 1'b0);
        expect_upd(8'hFF, 8'hFF, 1'b0);
        hold(H);
        apply(32'h4000_0000, 1'b1, 1'b1, 1'b0);
        expect_upd(8'hFF, 8'hFF, 1'b1);
        hold(H);

        // Pause pulse of S-1 cycles: filtered build keeps turbo=1
        apply(32'h4000_0000, 1'b0, 1'b1, 1'b0);
        if (!Filt) expect_upd(8'hFF, 8'hFF, 1'b0);
        hold(S - 1);
        apply(32'h4000_0000, 1'b1, 1'b1, 1'b0);
        if (!Filt) expect_upd(8'hFF, 8'hFF, 1'b1);
        hold(H);

        // Single-cycle pause glitch
        apply(32'h4000_0000, 1'b0, 1'b1, 1'b0);
        if (!Filt) expect_upd(8'hFF, 8'hFF, 1'b0);
        hold(1);
        apply(32'h4000_0000, 1'b1, 1'b1, 1'b0);
        if (!Filt) expect_upd(8'hFF, 8'hFF, 1'b1);
        hold(H);

        // Flip + test, status[28:22] all set -> dipsw_a=3F, dipsw_b=08
        apply(32'h1FC0_0000, 1'b1, 1'b0, 1'b1);
        expect_upd(8'h3F, 8'h08, 1'b0);
        hold(H);

        // Back to neutral, then status[17] set / cleared mid-count / set again
        apply(32'h0000_0000, 1'b1, 1'b1, 1'b0);
        expect_upd(8'hFF, 8'hFF, 1'b0);
        hold(H);
        apply(32'h0002_0000, 1'b1, 1'b1, 1'b0);
        if (!Filt) expect_upd(8'hFD, 8'hFF, 1'b0);
        hold(5);
        apply(32'h0000_0000, 1'b1, 1'b1, 1'b0);
        if (!Filt) expect_upd(8'hFF, 8'hFF, 1'b0);
        hold(5);
        apply(32'h0002_0000, 1'b1, 1'b1, 1'b0);
        expect_upd(8'hFD, 8'hFF, 1'b0);
        hold(H);

        // status[31] and status[29] do not affect any output
        apply(32'hA002_0000, 1'b1, 1'b1, 1'b0);
        hold(H);

        // Many bits together
        apply(32'h5FFF_0000, 1'b1, 1'b1, 1'b0);
        expect_upd(8'hC0, 8'h08, 1'b1);
        hold(H);

        // Reset mid-count, then the held input decodes after the normal latency
        apply(32'h0001_0000, 1'b1, 1'b1, 1'b0);
        if (!Filt) expect_upd(8'hFE, 8'hFF, 1'b0);
        hold(5);
        rst = 1'b1;
        begin
            exp_t e;
            e.val = {8'hFF, 8'hFF, 1'b0};
            e.cyc = cyc + 1;
            q.push_back(e);
        end
        hold(2);
        rst = 1'b0;
        expect_upd(8'hFE, 8'hFF, 1'b0);
        hold(H);

        hold(4);
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_update got=none want=%h@cyc%0d", e.val, e.cyc);
        end
        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end

endmodule
